// File: rtl/pwm_ramp_ctrl_pkg.sv
// Shared definitions for the PWM ramp sequencer: register map, CTRL/STATUS
// bit positions, downstream PWM duty offset and FSM state encoding.
package pwm_ramp_ctrl_pkg;

  localparam logic [7:0] OFS_CTRL     = 8'h00;
  localparam logic [7:0] OFS_START    = 8'h04;
  localparam logic [7:0] OFS_END      = 8'h08;
  localparam logic [7:0] OFS_STEP     = 8'h0C;
  localparam logic [7:0] OFS_INTERVAL = 8'h10;
  localparam logic [7:0] OFS_STATUS   = 8'h14;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_LOOP_BIT  = 1;
  localparam int CTRL_STOP_BIT  = 2;
  localparam int CTRL_CH_LSB    = 4;
  localparam int CH_W           = 4;

  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_DONE_BIT = 1;
  localparam int STAT_ERR_BIT  = 2;
  localparam int STAT_CUR_LSB  = 16;

  // Duty register offset inside each 16-byte PWM channel window.
  localparam logic [3:0] PWM_DUTY_OFS = 4'h8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } ramp_state_e;

endpackage

// File: rtl/pwm_ramp_ctrl.sv
// Duty-cycle ramp sequencer: steps a PWM channel's duty from START to END,
// sharing the downstream PWM bus with the CPU, which always has priority.
module pwm_ramp_ctrl
  import pwm_ramp_ctrl_pkg::*;
#(
  parameter logic [31:0] RAMP_BASE_ADDR = 32'h4000_3100,
  parameter logic [31:0] PWM_BASE_ADDR  = 32'h4000_3000,
  parameter int          PWM_NUM        = 2,
  parameter int          COUNTER_WIDTH  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_we,
  input  logic        mem_re,
  output logic [31:0] mem_rdata,
  output logic [31:0] pwm_addr,
  output logic [31:0] pwm_wdata,
  output logic        pwm_we,
  output logic        pwm_re,
  input  logic [31:0] pwm_rdata
);

  localparam int CW = COUNTER_WIDTH;
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW:0]   STEP_ONE = {{CW{1'b0}}, 1'b1};

  ramp_state_e r_state, w_state_nxt;

  logic [CW-1:0]   r_start_duty, r_end_duty, r_step, r_interval;
  logic [CW-1:0]   r_cur, r_target, r_cnt;
  logic            r_loop, r_dir_up, r_done, r_err;
  logic [CH_W-1:0] r_ch;

  logic            w_ramp_sel, w_pwm_sel, w_cpu_pwm, w_reg_wr, w_cfg_wr;
  logic            w_stop, w_start, w_launch, w_reject, w_ch_ok;
  logic            w_busy, w_grant, w_at_target;
  logic [7:0]      w_ofs;
  logic [CH_W-1:0] w_ch_eff;
  logic [CW:0]     w_step_eff, w_up_sum, w_dn_diff;
  logic [CW-1:0]   w_next_cur;
  logic [31:0]     w_reg_rdata;
  logic            w_unused_wdata;

  assign w_ramp_sel = (mem_addr[31:8] == RAMP_BASE_ADDR[31:8]);
  assign w_pwm_sel  = (mem_addr[31:8] == PWM_BASE_ADDR[31:8]);
  assign w_cpu_pwm  = (mem_we | mem_re) & w_pwm_sel;
  assign w_ofs      = mem_addr[7:0];
  assign w_reg_wr   = mem_we & w_ramp_sel;
  assign w_cfg_wr   = w_reg_wr & ~w_busy;

  // STOP outranks a START carried in the same CTRL write.
  assign w_stop   = w_reg_wr & (w_ofs == OFS_CTRL) & mem_wdata[CTRL_STOP_BIT];
  assign w_start  = w_reg_wr & (w_ofs == OFS_CTRL) & mem_wdata[CTRL_START_BIT] & ~w_stop;
  assign w_ch_eff = w_busy ? r_ch : mem_wdata[CTRL_CH_LSB +: CH_W];
  assign w_ch_ok  = ({{(32-CH_W){1'b0}}, w_ch_eff} < 32'(PWM_NUM));
  assign w_launch = w_start & w_ch_ok;
  assign w_reject = w_start & ~w_ch_ok;

  assign w_unused_wdata = &{1'b0, mem_wdata[31:CW]};

  // One extra bit so the step can neither wrap past 0 nor past the top code.
  assign w_step_eff  = (r_step == '0) ? STEP_ONE : {1'b0, r_step};
  assign w_up_sum    = {1'b0, r_cur} + w_step_eff;
  assign w_dn_diff   = {1'b0, r_cur} - w_step_eff;
  assign w_at_target = (r_cur == r_target);

  always_comb begin
    if (r_dir_up)
      w_next_cur = (w_up_sum >= {1'b0, r_target}) ? r_target : w_up_sum[CW-1:0];
    else
      w_next_cur = (w_dn_diff[CW] || (w_dn_diff[CW-1:0] <= r_target)) ? r_target
                                                                       : w_dn_diff[CW-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: each combinational output gets a default first so no path
  // through the block leaves it unassigned and infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    if (w_stop)
      w_state_nxt = S_IDLE;
    else if (w_launch)
      w_state_nxt = S_WRITE;
    else begin
      case (r_state)
        S_WRITE: if (w_grant) w_state_nxt = (w_at_target && !r_loop) ? S_DONE : S_WAIT;
        S_WAIT:  if (r_cnt == '0) w_state_nxt = S_WRITE;
        S_DONE:  w_state_nxt = S_IDLE;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_comb begin
    w_busy  = (r_state == S_WRITE) || (r_state == S_WAIT);
    w_grant = (r_state == S_WRITE) && !w_cpu_pwm && !w_stop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start_duty <= '0;
      r_end_duty   <= '0;
      r_step       <= '0;
      r_interval   <= '0;
      r_loop       <= 1'b0;
      r_ch         <= '0;
      r_cur        <= '0;
      r_target     <= '0;
      r_cnt        <= '0;
      r_dir_up     <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      if (w_cfg_wr) begin
        case (w_ofs)
          OFS_CTRL: begin
            r_loop <= mem_wdata[CTRL_LOOP_BIT];
            r_ch   <= mem_wdata[CTRL_CH_LSB +: CH_W];
          end
          OFS_START:    r_start_duty <= mem_wdata[CW-1:0];
          OFS_END:      r_end_duty   <= mem_wdata[CW-1:0];
          OFS_STEP:     r_step       <= mem_wdata[CW-1:0];
          OFS_INTERVAL: r_interval   <= mem_wdata[CW-1:0];
          default: ;
        endcase
      end

      if (w_reject) r_err <= 1'b1;

      if (w_launch) begin
        r_cur    <= r_start_duty;
        r_target <= r_end_duty;
        r_dir_up <= (r_start_duty <= r_end_duty);
        r_done   <= 1'b0;
        r_err    <= 1'b0;
      end else if (!w_stop) begin
        case (r_state)
          S_WRITE: if (w_grant) begin
            r_cnt <= r_interval;
            if (w_at_target) begin
              if (r_loop) begin
                r_dir_up <= ~r_dir_up;
                r_target <= (r_target == r_end_duty) ? r_start_duty : r_end_duty;
              end else begin
                r_done <= 1'b1;
              end
            end
          end
          S_WAIT: begin
            if (r_cnt == '0) r_cur <= w_next_cur;
            else             r_cnt <= r_cnt - CNT_ONE;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    w_reg_rdata = '0;
    case (w_ofs)
      OFS_CTRL: begin
        w_reg_rdata[CTRL_LOOP_BIT]        = r_loop;
        w_reg_rdata[CTRL_CH_LSB +: CH_W]  = r_ch;
      end
      OFS_START:    w_reg_rdata[CW-1:0] = r_start_duty;
      OFS_END:      w_reg_rdata[CW-1:0] = r_end_duty;
      OFS_STEP:     w_reg_rdata[CW-1:0] = r_step;
      OFS_INTERVAL: w_reg_rdata[CW-1:0] = r_interval;
      OFS_STATUS: begin
        w_reg_rdata[STAT_BUSY_BIT]       = w_busy;
        w_reg_rdata[STAT_DONE_BIT]       = r_done;
        w_reg_rdata[STAT_ERR_BIT]        = r_err;
        w_reg_rdata[STAT_CUR_LSB +: CW]  = r_cur;
      end
      default: ;
    endcase

    mem_rdata = '0;
    if (mem_re && w_ramp_sel)     mem_rdata = w_reg_rdata;
    else if (mem_re && w_pwm_sel) mem_rdata = pwm_rdata;
  end

  always_comb begin
    pwm_addr  = PWM_BASE_ADDR + {24'h0, r_ch, PWM_DUTY_OFS};
    pwm_wdata = {{(32-CW){1'b0}}, r_cur};
    pwm_we    = 1'b0;
    pwm_re    = 1'b0;
    if (w_cpu_pwm) begin
      pwm_addr  = mem_addr;
      pwm_wdata = mem_wdata;
      pwm_we    = mem_we;
      pwm_re    = mem_re;
    end else if (w_grant) begin
      pwm_we = 1'b1;
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl: expected PWM writes are queued as each
// ramp is launched and popped by a monitor as the DUT issues them.
module tb_pwm_ramp_ctrl;

  localparam logic [31:0] R = 32'h4000_3100;
  localparam logic [31:0] P = 32'h4000_3000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_re;
  logic [31:0] pwm_addr, pwm_wdata, pwm_rdata;
  logic        pwm_we, pwm_re;

  pwm_ramp_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .pwm_addr  (pwm_addr),
    .pwm_wdata (pwm_wdata),
    .pwm_we    (pwm_we),
    .pwm_re    (pwm_re),
    .pwm_rdata (pwm_rdata)
  );

  always #5 clk = ~clk;

  // Downstream PWM model: read data is a fixed function of the address.
  assign pwm_rdata = pwm_addr ^ 32'h5A5A_0000;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  wr_cyc[$];
  int  cyc = 0;
  int  passed = 0;
  int  total = 0;
  int  n_wr = 0;
  int  n_exp = 0;
  int  last_drive_cyc = 0;
  wr_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (pwm_we) begin
      n_wr++;
      wr_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_pwm_we", {31'b0, pwm_we}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("pwm_addr", pwm_addr, mon_e.addr);
        check("pwm_wdata", pwm_wdata, mon_e.data);
      end
    end
  end

  task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
    mem_addr  = a;
    mem_wdata = d;
    mem_we    = 1'b1;
    last_drive_cyc = cyc;
    @(posedge clk); #1;
    mem_we = 1'b0;
  endtask

  task automatic cpu_read(input logic [31:0] a, output logic [31:0] d);
    mem_addr = a;
    mem_re   = 1'b1;
    #4;
    d = mem_rdata;
    @(posedge clk); #1;
    mem_re = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    cpu_read(a, d);
    check(tag, d, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back('{addr: a, data: d});
    n_exp++;
  endtask

  task automatic drain(input string tag, input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    int          sc;

    mem_addr = '0; mem_wdata = '0; mem_we = 1'b0; mem_re = 1'b0;
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(1);

    // Reset state
    check("rst_pwm_we", {31'b0, pwm_we}, 32'd0);
    read_check("rst_status", R + 32'h14, 32'h0);
    read_check("rst_ctrl",   R + 32'h00, 32'h0);
    read_check("rst_start",  R + 32'h04, 32'h0);

    // Up ramp on channel 1
    cpu_write(R + 32'h04, 0);
    cpu_write(R + 32'h08, 100);
    cpu_write(R + 32'h0C, 25);
    cpu_write(R + 32'h10, 3);
    for (int v = 0; v <= 100; v += 25) expect_wr(P + 32'h18, v);
    wr_cyc.delete();
    cpu_write(R + 32'h00, 32'h11);
    sc = last_drive_cyc;
    drain("up_drain", 100);
    check("up_count", wr_cyc.size(), 5);
    if (wr_cyc.size() > 0) check("up_latency", wr_cyc[0], sc + 1);
    for (int i = 1; i < wr_cyc.size(); i++) check("up_spacing", wr_cyc[i] - wr_cyc[i-1], 5);
    idle(2);
    read_check("up_status", R + 32'h14, 32'h0064_0002);
    read_check("up_ctrl",   R + 32'h00, 32'h0000_0010);

    // Down ramp with saturation at 0; END write while busy is ignored
    cpu_write(R + 32'h04, 10);
    cpu_write(R + 32'h08, 0);
    cpu_write(R + 32'h0C, 4);
    cpu_write(R + 32'h10, 0);
    expect_wr(P + 32'h08, 10);
    expect_wr(P + 32'h08, 6);
    expect_wr(P + 32'h08, 2);
    expect_wr(P + 32'h08, 0);
    wr_cyc.delete();
    cpu_write(R + 32'h00, 32'h01);
    cpu_write(R + 32'h08, 50);
    drain("dn_drain", 100);
    if (wr_cyc.size() > 1) check("dn_spacing", wr_cyc[1] - wr_cyc[0], 2);
    idle(2);
    read_check("dn_status", R + 32'h14, 32'h0000_0002);
    read_check("dn_end_kept", R + 32'h08, 32'h0);

    // CPU read of the PWM page collides with the sequencer's WRITE cycle
    cpu_write(R + 32'h04, 7);
    cpu_write(R + 32'h08, 7);
    expect_wr(P + 32'h08, 7);
    wr_cyc.delete();
    cpu_write(R + 32'h00, 32'h01);
    sc = last_drive_cyc;
    mem_addr = P + 32'h0C;
    mem_re   = 1'b1;
    #4;
    check("cont_pwm_re",   {31'b0, pwm_re}, 32'd1);
    check("cont_pwm_we",   {31'b0, pwm_we}, 32'd0);
    check("cont_pwm_addr", pwm_addr, P + 32'h0C);
    check("cont_rdata",    mem_rdata, (P + 32'h0C) ^ 32'h5A5A_0000);
    @(posedge clk); #1;
    mem_re = 1'b0;
    drain("cont_drain", 20);
    if (wr_cyc.size() > 0) check("cont_cycle", wr_cyc[0], sc + 2);
    idle(3);
    check("cont_once", wr_cyc.size(), 1);

    // LOOP ramp, then STOP; START+STOP together must not launch
    cpu_write(R + 32'h04, 0);
    cpu_write(R + 32'h08, 2);
    cpu_write(R + 32'h0C, 1);
    cpu_write(R + 32'h10, 0);
    expect_wr(P + 32'h18, 0);
    expect_wr(P + 32'h18, 1);
    expect_wr(P + 32'h18, 2);
    expect_wr(P + 32'h18, 1);
    expect_wr(P + 32'h18, 0);
    expect_wr(P + 32'h18, 1);
    cpu_write(R + 32'h00, 32'h13);
    drain("loop_drain", 60);
    cpu_write(R + 32'h00, 32'h04);
    cpu_read(R + 32'h14, d);
    check("stop_flags", d & 32'h7, 32'h0);
    cpu_write(R + 32'h00, 32'h15);
    cpu_read(R + 32'h14, d);
    check("startstop_flags", d & 32'h7, 32'h0);
    idle(8);

    // Bad channel, then full-scale single-point ramp with STEP=0
    cpu_write(R + 32'h00, 32'h51);
    cpu_read(R + 32'h14, d);
    check("err_flags", d & 32'h7, 32'h4);
    idle(4);
    cpu_write(R + 32'h0C, 0);
    cpu_write(R + 32'h04, 32'hFFFF);
    cpu_write(R + 32'h08, 32'hFFFF);
    expect_wr(P + 32'h08, 32'h0000_FFFF);
    cpu_write(R + 32'h00, 32'h01);
    drain("max_drain", 20);
    idle(2);
    read_check("max_status", R + 32'h14, 32'hFFFF_0002);

    // Reset while waiting between steps
    cpu_write(R + 32'h04, 0);
    cpu_write(R + 32'h08, 100);
    cpu_write(R + 32'h0C, 10);
    cpu_write(R + 32'h10, 20);
    expect_wr(P + 32'h08, 0);
    cpu_write(R + 32'h00, 32'h01);
    drain("rstw_drain", 20);
    idle(5);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    read_check("rstw_status",   R + 32'h14, 32'h0);
    read_check("rstw_interval", R + 32'h10, 32'h0);
    read_check("rstw_ctrl",     R + 32'h00, 32'h0);
    idle(40);

    check("total_writes", n_wr, n_exp);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pwm_ramp_ctrl.md
PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  RAMP_BASE_ADDR  32'h40003100  base of this block's register page; decode on mem_addr[31:8].
  PWM_BASE_ADDR   32'h40003000  base of downstream PWM page; decode on mem_addr[31:8].
  PWM_NUM         2             number of PWM channels downstream.
  COUNTER_WIDTH   16            duty width.
REQ-002 Ports, one per line: name, direction, width, meaning. Clock clk and reset rst_n are listed first; rst_n is asynchronous and active-low.
  clk        in   1   clock
  rst_n      in   1   async active-low reset
  mem_addr   in   32  CPU address
  mem_wdata  in   32  CPU write data
  mem_we     in   1   CPU write strobe (single-cycle)
  mem_re     in   1   CPU read strobe
  mem_rdata  out  32  CPU read data (combinational)
  pwm_addr   out  32  PWM address
  pwm_wdata  out  32  PWM write data
  pwm_we     out  1   PWM write strobe
  pwm_re     out  1   PWM read strobe
  pwm_rdata  in   32  PWM read data
REQ-003 Register offsets SHALL be:
  0x00 CTRL: write-only strobes. bit0 START, bit1 LOOP (stored), bit2 STOP, bits7:4 CH (stored).
  0x04 START_DUTY.
  0x08 END_DUTY.
  0x0C STEP.
  0x10 INTERVAL.
  0x14 STATUS: read-only. bit0 BUSY, bit1 DONE, bit2 ERR, bits31:16 CUR_DUTY.

Function
REQ-004 mem_rdata SHALL return this block's register when (RAMP page & mem_re), pwm_rdata when (PWM page & mem_re), and 0 otherwise.
  - Unused bits and unmapped offsets read 0.
  - CTRL reads {LOOP, CH}.
REQ-005 The CPU SHALL have absolute priority on the PWM port.
  - In any cycle with (mem_we|mem_re) & PWM page, pwm_addr/wdata/we/re = CPU signals.
  - Otherwise, pwm_* are driven by the sequencer grant (REQ-009), else pwm_we = pwm_re = 0.
REQ-006 FSM states SHALL be IDLE, WRITE, WAIT, DONE.
REQ-007 START with CH < PWM_NUM SHALL, from any state:
  - load CUR = START_DUTY;
  - set dir = up if START_DUTY <= END_DUTY, else down;
  - clear DONE and ERR;
  - enter WRITE.
REQ-008 START with CH >= PWM_NUM SHALL set ERR and leave the state unchanged.
REQ-009 In WRITE, in the first cycle the CPU does not claim the PWM port, the block SHALL issue exactly one write:
  - pwm_we = 1;
  - pwm_addr = PWM_BASE_ADDR + CH*16 + 8;
  - pwm_wdata = zero-extended CUR.
REQ-010 After the granted write, the FSM SHALL transition as follows:
  - if CUR == current target and LOOP = 0 -> DONE;
  - if CUR == current target and LOOP = 1 -> invert direction, swap target (END <-> START), load interval counter, go to WAIT;
  - otherwise load interval counter with INTERVAL and go to WAIT.
REQ-011 WAIT SHALL decrement the interval counter each cycle; when the counter is 0 it SHALL step CUR toward the target and return to WRITE.
  - INTERVAL = 0 gives 1 WAIT cycle.
REQ-012 Step arithmetic SHALL use COUNTER_WIDTH+1 bits and saturate at the target, with no wrap-around past 0 or 2^COUNTER_WIDTH-1.
  - STEP = 0 is treated as 1.
REQ-013 DONE SHALL set STATUS.DONE (sticky until next START), deassert BUSY, and go to IDLE the next cycle.
REQ-014 STOP SHALL force IDLE in the next cycle, drop any pending write, and leave DONE unchanged.
  - If START and STOP are written together, STOP wins.
REQ-015 BUSY SHALL be 1 in WRITE and WAIT.
REQ-016 Writes to START_DUTY, END_DUTY, STEP, INTERVAL, LOOP or CH while BUSY SHALL be ignored; STOP/START remain effective.
REQ-017 Latency: a START write in cycle N SHALL produce the first pwm_we at cycle N+1 at the earliest.

Reset
REQ-018 On rst_n low, the block SHALL asynchronously set:
  - FSM = IDLE;
  - all config registers, CUR, counter, DONE and ERR = 0;
  - pwm_we = pwm_re = 0 unless the CPU is passing through; mem_rdata follows REQ-004.
REQ-019 Reset asserted mid-ramp SHALL abort without issuing a further PWM write.

Structure
REQ-020 Register offsets, CTRL/STATUS bit positions and FSM state encodings SHALL live in a shared peripheral package/include.
REQ-021 The block SHALL be a single module with no sub-modules.
  - Base-address and channel decode are inline.
  - The downstream pwm instance is connected by the top level.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
  - Up ramp: START=0, END=100, STEP=25, INTERVAL=3, CH=1, START -> DUTY writes 0,25,50,75,100 at 0x40003018, 4 WAIT cycles apart; then DONE=1, BUSY=0.
  - Down ramp with saturation: START=10, END=0, STEP=4 -> writes 10,6,2,0; DONE set.
  - Contention: CPU reads 0x4000300C in the same cycle the sequencer is in WRITE -> CPU passes through; sequencer write appears the next free cycle, same data, issued once.
  - LOOP: START=0, END=2, STEP=1, INTERVAL=0 -> writes 0,1,2,1,0,1 continuously; STOP -> IDLE next cycle, no further pwm_we, DONE=0.
  - Errors and boundaries: CH=5 START -> ERR=1, BUSY=0, no pwm_we; STEP=0, START=END=0xFFFF -> single write of 0xFFFF, then DONE.
  - Reset mid-WAIT -> all STATUS reads 0 and no pwm_we after reset.
